bw_io_impctl_upd_sched: RTL and testbench



---
 rtl/bw_io_impctl_upd_sched.sv | 111 +++++++++++
 tb/tb_bw_io_impctl_upd_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bw_io_impctl_upd_sched.sv
// Impedance-code update scheduler: round-robin arbitration over NREQ channels,
// serial MSB-first broadcast of the winning code, one-cycle bank update strobe,
// then a quiet gap before the next transfer.
module bw_io_impctl_upd_sched #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 8,
    parameter int GAP    = 3,
    parameter int SEL_W  = 2
) (
    input  logic                     l2clk,
    input  logic                     hard_reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CODE_W-1:0]   code_in,
    input  logic                     freeze,
    output logic [NREQ-1:0]          gnt,
    output logic [SEL_W-1:0]         bank_sel,
    output logic                     sclk_en,
    output logic                     sdata,
    output logic                     upd_strobe,
    output logic                     busy
);

    localparam int BC_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_STROBE = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr;       // last granted channel
    logic [SEL_W-1:0] pick;
    logic             pick_vld;
    int               arb_idx;
    logic [CODE_W-1:0] shreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [3:0]       gap_cnt;

    // Round-robin pick: first asserted req scanning upward from ptr+1, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        arb_idx  = 0;
        for (int off = 1; off <= NREQ; off++) begin
            arb_idx = int'(ptr) + off;
            if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
            if (!pick_vld && req[arb_idx]) begin
                pick     = SEL_W'(arb_idx);
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!freeze && pick_vld) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SHIFT;
            S_SHIFT:  if (bit_cnt == '0) state_nxt = S_STROBE;
            S_STROBE: state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:    if (gap_cnt == '0) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge l2clk or negedge hard_reset_n) begin
        if (!hard_reset_n) state <= S_IDLE;
        else               state <= state_nxt;
    end

    // Datapath: selection, code capture, shifting and gap counting.
    always_ff @(posedge l2clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            bank_sel <= '0;
            ptr      <= SEL_W'(NREQ - 1);
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == S_IDLE && state_nxt == S_LOAD) bank_sel <= pick;
            if (state == S_LOAD) begin
                // Code is taken from the LOAD-cycle value of the granted channel.
                shreg   <= code_in[int'(bank_sel)*CODE_W +: CODE_W];
                ptr     <= bank_sel;
                bit_cnt <= BC_W'(CODE_W - 1);
            end
            if (state == S_SHIFT) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (state == S_STROBE) gap_cnt <= 4'((GAP > 0) ? GAP - 1 : 0);
            if (state == S_GAP)    gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Outputs are pure state decodes so reset drops them immediately.
    always_comb begin
        gnt = '0;
        if (state == S_LOAD) gnt[bank_sel] = 1'b1;
        sclk_en    = (state == S_SHIFT);
        sdata      = (state == S_SHIFT) & shreg[CODE_W-1];
        upd_strobe = (state == S_STROBE);
        busy       = (state != S_IDLE);
    end

endmodule

// File: tb/tb_bw_io_impctl_upd_sched.sv
// Scoreboard bench for bw_io_impctl_upd_sched: stimulus pushes the expected
// transfer (channel, code, grant spacing); a negedge monitor reassembles the
// serial stream and checks it at each upd_strobe.
module tb_bw_io_impctl_upd_sched;

    localparam int NREQ = 4, CODE_W = 8, SEL_W = 2;

    typedef struct {
        int         ch;
        logic [7:0] code;
        int         spacing;   // 0 = don't check grant-to-grant distance
    } exp_t;

    logic                   l2clk = 1'b0;
    logic                   hard_reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*CODE_W-1:0] code_in;
    logic                   freeze;
    logic [NREQ-1:0]        gnt;
    logic [SEL_W-1:0]       bank_sel;
    logic                   sclk_en, sdata, upd_strobe, busy;

    // GAP=0 build, driven separately
    logic                   rst0_n;
    logic [NREQ-1:0]        req0;
    logic [NREQ*CODE_W-1:0] code0;
    logic                   freeze0;
    logic [NREQ-1:0]        gnt0;
    logic [SEL_W-1:0]       bank_sel0;
    logic                   sclk0, sdata0, upd0, busy0;

    int tests = 0, fails = 0;
    exp_t exp_q[$];

    bw_io_impctl_upd_sched #(.NREQ(NREQ), .CODE_W(CODE_W), .GAP(3), .SEL_W(SEL_W)) u_dut (
        .l2clk(l2clk), .hard_reset_n(hard_reset_n), .req(req), .code_in(code_in),
        .freeze(freeze), .gnt(gnt), .bank_sel(bank_sel), .sclk_en(sclk_en),
        .sdata(sdata), .upd_strobe(upd_strobe), .busy(busy));

    bw_io_impctl_upd_sched #(.NREQ(NREQ), .CODE_W(CODE_W), .GAP(0), .SEL_W(SEL_W)) u_dut_g0 (
        .l2clk(l2clk), .hard_reset_n(rst0_n), .req(req0), .code_in(code0),
        .freeze(freeze0), .gnt(gnt0), .bank_sel(bank_sel0), .sclk_en(sclk0),
        .sdata(sdata0), .upd_strobe(upd0), .busy(busy0));

    always #5 l2clk = ~l2clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge l2clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            tick(1);
            n++;
        end
        chk("wait_idle_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic set_code(input int ch, input logic [7:0] v);
        code_in[ch*CODE_W +: CODE_W] = v;
    endtask

    // Monitor: grant order/spacing, serial reassembly, strobe checks.
    int         mcyc = 0, last_gnt = 0, gnt_cyc = 0, nbits = 0;
    logic [7:0] sh = '0;
    exp_t       e;
    always @(negedge l2clk) begin
        mcyc++;
        if (!hard_reset_n) begin
            nbits = 0;
            sh    = '0;
        end else begin
            if (gnt !== '0) begin
                if (exp_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
                else begin
                    chk("gnt_onehot", 32'(gnt), 32'(1 << exp_q[0].ch));
                    if (exp_q[0].spacing != 0)
                        chk("gnt_spacing", 32'(mcyc - last_gnt), 32'(exp_q[0].spacing));
                end
                last_gnt = mcyc;
                gnt_cyc  = mcyc;
                nbits    = 0;
            end
            if (sclk_en) begin
                sh = {sh[6:0], sdata};
                nbits++;
            end
            if (upd_strobe) begin
                if (exp_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("strobe_bank_sel", 32'(bank_sel), 32'(e.ch));
                    chk("serial_code", 32'(sh), 32'(e.code));
                    chk("serial_nbits", 32'(nbits), 32'(CODE_W));
                    chk("gnt_to_strobe", 32'(mcyc - gnt_cyc), 32'(CODE_W + 1));
                end
                nbits = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hard_reset_n = 1'b0; req = '0; code_in = '0; freeze = 1'b0;
        rst0_n = 1'b0; req0 = '0; code0 = '0; freeze0 = 1'b0;
        tick(2);
        // reset values
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_bank_sel", 32'(bank_sel), 32'd0);
        chk("rst_sclk_en", 32'(sclk_en), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_upd_strobe", 32'(upd_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // 1: single requester ch0, code A5
        set_code(0, 8'hA5); req = 4'b0001;
        exp_q.push_back('{0, 8'hA5, 0});
        hard_reset_n = 1'b1;
        tick(1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick(12);
        chk("t1_busy_gap", 32'(busy), 32'd1);
        tick(1);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        wait_idle();

        // 2: all four requesting from fresh reset -> 0,1,2,3,0 at 14-cycle spacing
        hard_reset_n = 1'b0; tick(1);
        set_code(0, 8'h11); set_code(1, 8'h22); set_code(2, 8'h33); set_code(3, 8'h44);
        req = 4'b1111;
        exp_q.push_back('{0, 8'h11, 0});
        exp_q.push_back('{1, 8'h22, 14});
        exp_q.push_back('{2, 8'h33, 14});
        exp_q.push_back('{3, 8'h44, 14});
        exp_q.push_back('{0, 8'h11, 14});
        hard_reset_n = 1'b1;
        tick(57);
        chk("t2_fifth_gnt", 32'(gnt), 32'h1);
        req = '0;
        wait_idle();

        // 3: after a ch1 grant, ch0 wins before ch1 again
        hard_reset_n = 1'b0; tick(1);
        set_code(0, 8'h5A); set_code(1, 8'hC3);
        req = 4'b0010;
        exp_q.push_back('{1, 8'hC3, 0});
        exp_q.push_back('{0, 8'h5A, 14});
        exp_q.push_back('{1, 8'hC3, 14});
        hard_reset_n = 1'b1;
        tick(1);
        req = 4'b0011;
        tick(28);
        req = '0;
        wait_idle();

        // 4: freeze holds off a new transfer but not an in-flight one
        freeze = 1'b1; set_code(2, 8'h96); req = 4'b0100;
        tick(20);
        chk("t4_frozen_busy", 32'(busy), 32'd0);
        chk("t4_frozen_gnt", 32'(gnt), 32'd0);
        exp_q.push_back('{2, 8'h96, 0});
        freeze = 1'b0;
        tick(1);
        chk("t4_gnt2", 32'(gnt), 32'h4);
        req = '0;
        tick(3);
        freeze = 1'b1;
        wait_idle();
        freeze = 1'b0;

        // 5: code change during SHIFT is ignored
        set_code(0, 8'h0F); req = 4'b0001;
        exp_q.push_back('{0, 8'h0F, 0});
        tick(1);
        chk("t5_gnt0", 32'(gnt), 32'h1);
        req = '0;
        tick(3);
        set_code(0, 8'hF0);
        wait_idle();

        // 6: reset on 4th SHIFT cycle aborts without strobe
        set_code(0, 8'h3C); req = 4'b0001;
        exp_q.push_back('{0, 8'h3C, 0});
        tick(1);
        req = '0;
        tick(4);
        chk("t6_in_shift", 32'(sclk_en), 32'd1);
        hard_reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_abort_sclk_en", 32'(sclk_en), 32'd0);
        chk("t6_abort_sdata", 32'(sdata), 32'd0);
        chk("t6_abort_busy", 32'(busy), 32'd0);
        tick(3);
        set_code(3, 8'hE7); req = 4'b1000;
        exp_q.push_back('{3, 8'hE7, 0});
        hard_reset_n = 1'b1;
        tick(1);
        chk("t6_gnt3", 32'(gnt), 32'h8);
        req = '0;
        wait_idle();

        // GAP=0 build: STROBE -> IDLE directly, 11-cycle grant spacing
        code0[3*CODE_W +: CODE_W] = 8'h81; req0 = 4'b1000;
        rst0_n = 1'b1;
        tick(1);
        chk("g0_gnt_first", 32'(gnt0), 32'h8);
        tick(9);
        chk("g0_strobe", 32'(upd0), 32'd1);
        chk("g0_bank_sel", 32'(bank_sel0), 32'd3);
        tick(1);
        chk("g0_idle_after_strobe", 32'(busy0), 32'd0);
        tick(1);
        chk("g0_gnt_spacing11", 32'(gnt0), 32'h8);
        req0 = '0;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
